detect_event_logger: RTL and testbench
======================================

// Module: detect_event_logger
// PURPOSE
//  Downstream consumer of the 01110 pattern detector's one-cycle Z pulse.
//  - Timestamps every detection with a free-running cycle counter.
//  - Buffers the timestamps in a small FIFO and drains them over a valid/ready port.
//  - Keeps a saturating total-hit count and a sticky overflow flag, for the bench/host.
// PARAMETERS
//  TS_W   16  width of timestamp counter and of each FIFO entry
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CNT_W  8   width of saturating hit counter
// PORTS
//  Interface: one clock; reset is synchronous and active-high.
//  clk      in   1                  clock; all logic on posedge
//  clr      in   1                  reset; sync, active-high; flushes everything
//  Z        in   1                  detection pulse from detector; 1 = hit this cycle
//  ovf_clr  in   1                  one-cycle pulse, clears overflow
//  m_valid  out  1                  m_ts holds the oldest buffered timestamp
//  m_ready  in   1                  consumer accepts; pop when m_valid & m_ready
//  m_ts     out  TS_W               head timestamp; 0 when empty
//  level    out  $clog2(DEPTH+1)    number of entries held
//  hit_cnt  out  CNT_W              total hits since reset, saturating
//  overflow out  1                  sticky: a hit was dropped on full FIFO
// BEHAVIOUR
//  Reset (clr=1 at posedge):
//   - ts, level, hit_cnt and overflow all 0; m_valid=0; m_ts=0.
//   - In-flight FIFO contents are discarded, including when asserted mid-stream.
//   - Z in the reset cycle is ignored.
//  Timestamp ts:
//   - 0 in the first cycle after reset, +1 every cycle.
//   - Wraps from 2^TS_W-1 to 0 with no flag.
//  Push:
//   - Z=1 at a posedge pushes the current ts value (the value before that edge's increment).
//  Latency:
//   - The entry is visible no earlier than the next cycle: m_valid=1 the cycle after the push.
//   - There is no same-cycle bypass; an empty FIFO with Z=1 and m_ready=1 does not pop.
//  Pop:
//   - On m_valid & m_ready at a posedge, the head is removed.
//   - m_ts is registered FIFO data and is stable while m_valid=1 & m_ready=0.
//  Full FIFO (level==DEPTH):
//   - Z=1 with no pop: the entry is dropped and overflow is set.
//   - Z=1 with a pop in the same cycle: both happen; level stays DEPTH; no overflow.
//  Empty FIFO:
//   - m_valid=0, m_ts=0.
//   - m_ready is ignored.
//  hit_cnt:
//   - +1 on every Z=1, including dropped hits.
//   - Holds at 2^CNT_W-1.
//  overflow:
//   - Cleared by ovf_clr.
//   - If a set and ovf_clr land in the same cycle, set wins (overflow=1).
//  Pointers: rd/wr pointers are log2(DEPTH) bits and wrap naturally; level disambiguates full from empty.
//  FSM: none beyond the FIFO occupancy; all outputs are registered.
// STRUCTURE
//  - Package detect_pkg: TS_W default and typedef ts_t = logic [TS_W-1:0]; shared with the detector bench.
//  - Sub-module detect_ts_fifo: sync FIFO with push/pop/level/full/empty and registered head output.
//  - Top level: ts counter, hit counter, overflow flag, push/drop decision.
// TESTING
//  T1 reset
//   - clr=1 for 10 cycles, then release; Z=0.
//   - Expect: ts counts from 0; all outputs 0; m_valid=0.
//  T2 single hit
//   - Z=1 one cycle at ts=5; m_ready=0.
//   - Expect: next cycle m_valid=1, m_ts=5, level=1, hit_cnt=1.
//   - Then m_ready=1 for one cycle -> level=0, m_valid=0.
//  T3 overflow and clear (DEPTH=4)
//   - 5 back-to-back hits at ts=20..24, m_ready=0.
//   - Expect: level=4; FIFO holds 20,21,22,23; 24 dropped; overflow=1; hit_cnt=5.
//   - ovf_clr pulse -> overflow=0.
//  T4 full with simultaneous push/pop
//   - FIFO full (20..23); Z=1 at ts=30 with m_ready=1.
//   - Expect: 20 popped; 30 stored; level=4; overflow stays 0.
//   - Drain order: 21,22,23,30.
//  T5 wrap and saturation (TS_W=4, CNT_W=3)
//   - Hit at ts=15, then at ts=0 (next cycle), then 6 more hits.
//   - Expect: timestamps 15 then 0 in order; hit_cnt saturates at 7.
//  T6 reset mid-stream
//   - FIFO level=3; assert clr one cycle with Z=1.
//   - Expect: next cycle level=0, m_valid=0, hit_cnt=0, ts=0; nothing stored.
//  Random
//   - Drive Z from the detector; random m_ready.
//   - Scoreboard: timestamp queue model checks FIFO order and drops.

Source files
------------

// File: rtl/detect_pkg.sv
// rtl/detect_pkg.sv - shared widths and timestamp type for the 01110 detector and its event logger
package detect_pkg;
    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;
endpackage

// File: rtl/detect_ts_fifo.sv
// rtl/detect_ts_fifo.sv - synchronous timestamp FIFO with registered head, valid and level
module detect_ts_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output logic          valid_o,
    output logic [W-1:0]  head_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q;
    logic          do_push;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;

    always_comb begin
        do_push = push_i && (!full_o || pop_i);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(pop_i);
        level_d = level_q + LW'(do_push) - LW'(pop_i);
        head_d  = '0;
        // A push into a FIFO that is empty after this edge's pop becomes the new head directly.
        if (level_d != '0) begin
            head_d = (do_push && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            head_q  <= head_d;
            valid_q <= (level_d != '0);
        end
    end
endmodule

// File: rtl/detect_event_logger.sv
// rtl/detect_event_logger.sv - timestamps detector hits, buffers them and drains over valid/ready
module detect_event_logger
    import detect_pkg::*;
#(
    parameter  int TS_W  = TS_W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             Z,
    input  logic             ovf_clr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [TS_W-1:0]  m_ts,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             overflow
);
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, pop, drop;

    assign pop = m_ready && !empty;

    always_comb begin
        ts_d  = ts_q + TS_W'(1);
        hit_d = hit_q;
        if (Z && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
        // A pop in the same cycle frees the slot, so only a hit on a full, stalled FIFO is lost.
        drop  = Z && full && !pop;
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ts_q  <= '0;
            hit_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            hit_q <= hit_d;
            ovf_q <= ovf_d;
        end
    end

    detect_ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .clr         (clr),
        .push_i      (Z),
        .push_data_i (ts_q),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (level),
        .valid_o     (m_valid),
        .head_o      (m_ts)
    );

    assign hit_cnt  = hit_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_detect_event_logger.sv
// tb/tb_detect_event_logger.sv - scoreboard bench for detect_event_logger
module tb_detect_event_logger;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clr, z, ovf_clr, m_ready;
    logic        m_valid, overflow;
    logic [15:0] m_ts;
    logic [2:0]  level;
    logic [7:0]  hit_cnt;

    logic        clr2, z2, rdy2, m_valid2, ovf2;
    logic [3:0]  m_ts2;
    logic [2:0]  level2, hit2;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mdl_ts;
    logic [7:0]  mdl_hits;
    logic        mdl_ovf;

    always #5 clk = ~clk;

    detect_event_logger dut (
        .clk(clk), .clr(clr), .Z(z), .ovf_clr(ovf_clr), .m_valid(m_valid), .m_ready(m_ready),
        .m_ts(m_ts), .level(level), .hit_cnt(hit_cnt), .overflow(overflow)
    );

    detect_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) dut_small (
        .clk(clk), .clr(clr2), .Z(z2), .ovf_clr(1'b0), .m_valid(m_valid2), .m_ready(rdy2),
        .m_ts(m_ts2), .level(level2), .hit_cnt(hit2), .overflow(ovf2)
    );

    // Advance the model by one edge using the inputs currently applied, then clock the DUT.
    task automatic step();
        if (clr) begin
            mdl_ts = '0;
            exp_q.delete();
            mdl_hits = '0;
            mdl_ovf = 1'b0;
        end else begin
            bit pop, full, lost;
            full = (exp_q.size() == DEPTH);
            pop  = m_ready && (exp_q.size() > 0);
            lost = z && full && !pop;
            if (pop) void'(exp_q.pop_front());
            if (z) begin
                if (mdl_hits != 8'hFF) mdl_hits++;
                if (!lost) exp_q.push_back(mdl_ts);
            end
            if (lost) mdl_ovf = 1'b1;
            else if (ovf_clr) mdl_ovf = 1'b0;
            mdl_ts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (10) step();
        clr = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %0b want 0", m_valid); end
        checks++; if (m_ts !== 16'd0) begin failures++; $display("FAIL reset_ts got %0d want 0", m_ts); end
        checks++; if (hit_cnt !== 8'd0) begin failures++; $display("FAIL reset_hits got %0d want 0", hit_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    endtask

    task automatic test_single_hit();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (5) step();
        z = 1'b1; step(); z = 1'b0;
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid got %0b want 1", m_valid); end
        checks++; if (m_ts !== 16'd5) begin failures++; $display("FAIL single_ts got %0d want 5", m_ts); end
        checks++; if (m_ts !== exp_q[0]) begin failures++; $display("FAIL single_sb got %0d want %0d", m_ts, exp_q[0]); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got %0d want 1", level); end
        checks++; if (hit_cnt !== 8'd1) begin failures++; $display("FAIL single_hits got %0d want 1", hit_cnt); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_pop_level got %0d want 0", level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got %0b want 0", m_valid); end
        checks++; if (m_ts !== 16'd0) begin failures++; $display("FAIL single_pop_ts got %0d want 0", m_ts); end
    endtask

    task automatic test_overflow();
        clr = 1'b1; step(); clr = 1'b0;
        repeat (20) step();
        z = 1'b1; repeat (5) step(); z = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level got %0d want 4", level); end
        checks++; if (m_ts !== 16'd20) begin failures++; $display("FAIL ovf_head got %0d want 20", m_ts); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        checks++; if (hit_cnt !== 8'd5) begin failures++; $display("FAIL ovf_hits got %0d want 5", hit_cnt); end
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got %0b want 0", overflow); end
        checks++; if (m_ts !== 16'd20) begin failures++; $display("FAIL ovf_stable got %0d want 20", m_ts); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] drain [4] = '{16'd21, 16'd22, 16'd23, 16'd30};
        repeat (4) step();
        z = 1'b1; m_ready = 1'b1; step(); z = 1'b0; m_ready = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_level got %0d want 4", level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_valid !== 1'b1 || m_ts !== drain[i]) begin
                failures++; $display("FAIL fpp_drain%0d got %0d/%0b want %0d/1", i, m_ts, m_valid, drain[i]);
            end
            step();
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0 || level !== 3'd0) begin
            failures++; $display("FAIL fpp_empty got valid=%0b level=%0d want 0/0", m_valid, level);
        end
    endtask

    task automatic test_no_bypass();
        z = 1'b1; m_ready = 1'b1; step(); z = 1'b0; m_ready = 1'b0;
        checks++; if (level !== 3'd1 || m_valid !== 1'b1) begin
            failures++; $display("FAIL bypass got level=%0d valid=%0b want 1/1", level, m_valid);
        end
        checks++; if (m_ts !== exp_q[0]) begin failures++; $display("FAIL bypass_ts got %0d want %0d", m_ts, exp_q[0]); end
        m_ready = 1'b1; step(); m_ready = 1'b0;
    endtask

    task automatic test_wrap_sat();
        clr2 = 1'b1; step(); clr2 = 1'b0;
        repeat (15) step();
        z2 = 1'b1; repeat (8) step(); z2 = 1'b0;
        checks++; if (m_ts2 !== 4'd15 || m_valid2 !== 1'b1) begin
            failures++; $display("FAIL wrap_head got %0d/%0b want 15/1", m_ts2, m_valid2);
        end
        checks++; if (hit2 !== 3'd7) begin failures++; $display("FAIL sat_hits got %0d want 7", hit2); end
        checks++; if (level2 !== 3'd4 || ovf2 !== 1'b1) begin
            failures++; $display("FAIL wrap_full got level=%0d ovf=%0b want 4/1", level2, ovf2);
        end
        rdy2 = 1'b1; step(); rdy2 = 1'b0;
        checks++; if (m_ts2 !== 4'd0 || level2 !== 3'd3) begin
            failures++; $display("FAIL wrap_next got %0d level=%0d want 0/3", m_ts2, level2);
        end
    endtask

    task automatic test_reset_mid();
        clr = 1'b1; step(); clr = 1'b0;
        z = 1'b1; repeat (3) step(); z = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_pre_level got %0d want 3", level); end
        clr = 1'b1; z = 1'b1; step(); clr = 1'b0; z = 1'b0;
        checks++; if (level !== 3'd0 || m_valid !== 1'b0 || hit_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_clr got level=%0d valid=%0b hits=%0d want 0/0/0", level, m_valid, hit_cnt);
        end
        z = 1'b1; step(); z = 1'b0;
        checks++; if (m_ts !== 16'd0 || hit_cnt !== 8'd1) begin
            failures++; $display("FAIL mid_ts got ts=%0d hits=%0d want 0/1", m_ts, hit_cnt);
        end
    endtask

    task automatic test_random();
        logic [4:0]  hist = '0;
        logic [15:0] eh;
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            hist    = {hist[3:0], 1'($urandom_range(0, 1))};
            z       = (hist == 5'b01110);
            m_ready = (i < 750) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 1) == 1);
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
            eh = (exp_q.size() > 0) ? exp_q[0] : 16'd0;
            checks++; if (m_valid !== (exp_q.size() > 0) || m_ts !== eh || level !== 3'(exp_q.size())) begin
                failures++; $display("FAIL rand_fifo cyc %0d got %0b/%0d/%0d want %0b/%0d/%0d",
                    i, m_valid, m_ts, level, exp_q.size() > 0, eh, exp_q.size());
            end
            checks++; if (hit_cnt !== mdl_hits || overflow !== mdl_ovf) begin
                failures++; $display("FAIL rand_stat cyc %0d got %0d/%0b want %0d/%0b",
                    i, hit_cnt, overflow, mdl_hits, mdl_ovf);
            end
        end
        z = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; z = 1'b0; ovf_clr = 1'b0; m_ready = 1'b0;
        clr2 = 1'b1; z2 = 1'b0; rdy2 = 1'b0;
        mdl_ts = '0; mdl_hits = '0; mdl_ovf = 1'b0;
        test_reset();
        test_single_hit();
        test_overflow();
        test_full_push_pop();
        test_no_bypass();
        test_wrap_sat();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
